bcd_scan_display: RTL and testbench

//  Consumer end of the countdown timer's display interface.

---
 rtl/ece385_display_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/bcd_scan_display.sv | 169 ++++++++++++++++
 tb/tb_bcd_scan_display.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ece385_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package ece385_display_pkg;

    // Active-low segment vector ordered {g,f,e,d,c,b,a}.
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_DASH  = 7'h3F;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } blink_phase_t;

    // True when a nibble is not a legal BCD digit.
    function automatic logic nibble_invalid(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

    // True when any digit of a packed 4-digit BCD value is illegal.
    function automatic logic bcd_word_invalid(input logic [15:0] word);
        return nibble_invalid(word[15:12]) | nibble_invalid(word[11:8]) |
               nibble_invalid(word[7:4])   | nibble_invalid(word[3:0]);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment glyph decoder.
// Nibbles above 9 produce a dash so a bad digit is visible on the panel.
module bcd_to_seg7
    import ece385_display_pkg::*;
(
    input  logic [3:0] bcd,
    output seg7_t      seg
);

    // Glyph lookup for the ten decimal digits.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed 4-digit 7-segment driver for the countdown timer.
// A frame-aligned shadow copy of the time value prevents tearing; each digit
// slot opens with a short all-anodes-off window to suppress ghosting.
module bcd_scan_display
    import ece385_display_pkg::*;
#(
    parameter int          SCAN_DIV     = 50_000,
    parameter int          GHOST_CYCLES = 500,
    parameter int          BLINK_DIV    = 12_500_000,
    parameter logic [15:0] WARN_THRESH  = 16'h0010
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] time_display,
    input  logic        run_out,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        warn,
    output logic        bcd_error
);

    localparam int SLOT_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SLOT_W-1:0]  slot_cnt_r;
    logic [1:0]         idx_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    blink_phase_t       phase_r;
    logic [15:0]        shadow_r;
    logic               run_shadow_r;
    logic               warn_r;
    logic               bcd_error_r;
    seg7_t              seg_n_r;
    logic [3:0]         an_n_r;

    logic               slot_wrap_s;
    logic               frame_end_s;
    logic               blinking_s;
    logic [3:0]         digit_nib_s;
    logic               digit_blank_s;
    seg7_t              digit_glyph_s;
    seg7_t              seg_next_s;
    logic [3:0]         an_next_s;

    assign slot_wrap_s = (slot_cnt_r == SLOT_W'(SCAN_DIV - 1));
    assign frame_end_s = slot_wrap_s && (idx_r == 2'd3);
    assign blinking_s  = run_shadow_r || warn_r;

    // Pick the current digit nibble and decide leading-zero blanking.
    always_comb begin
        digit_nib_s   = shadow_r[3:0];
        digit_blank_s = 1'b0;
        case (idx_r)
            2'd0: begin
                digit_nib_s   = shadow_r[3:0];
                digit_blank_s = 1'b0;
            end
            2'd1: begin
                digit_nib_s   = shadow_r[7:4];
                digit_blank_s = (shadow_r[15:4] == 12'h000);
            end
            2'd2: begin
                digit_nib_s   = shadow_r[11:8];
                digit_blank_s = (shadow_r[15:8] == 8'h00);
            end
            2'd3: begin
                digit_nib_s   = shadow_r[15:12];
                digit_blank_s = (shadow_r[15:12] == 4'h0);
            end
            default: begin
                digit_nib_s   = shadow_r[3:0];
                digit_blank_s = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (digit_nib_s),
        .seg (digit_glyph_s)
    );

    // Segment and anode values for the next edge, error dash taking priority.
    always_comb begin
        seg_next_s = digit_glyph_s;
        an_next_s  = ~(4'b0001 << idx_r);
        if (bcd_error_r) begin
            seg_next_s = SEG_DASH;
        end else if (digit_blank_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = digit_glyph_s;
        end
        if ((slot_cnt_r < SLOT_W'(GHOST_CYCLES)) ||
            (blinking_s && (phase_r == PH_OFF))) begin
            an_next_s = 4'hF;
        end else begin
            an_next_s = ~(4'b0001 << idx_r);
        end
    end

    // Slot counter and digit index; the index steps once per slot wrap.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_cnt_r <= '0;
            idx_r      <= 2'd0;
        end else if (slot_wrap_s) begin
            slot_cnt_r <= '0;
            idx_r      <= idx_r + 2'd1;
        end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
        end
    end

    // Blink timebase; parked at count 0 / phase ON whenever not blinking.
    always_ff @(posedge Clk) begin
        if (Reset || !blinking_s) begin
            blink_cnt_r <= '0;
            phase_r     <= PH_ON;
        end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_r <= '0;
            phase_r     <= (phase_r == PH_ON) ? PH_OFF : PH_ON;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Capture the input only at frame boundaries so a frame never mixes values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow_r     <= 16'h0000;
            run_shadow_r <= 1'b0;
        end else if (frame_end_s) begin
            shadow_r     <= time_display;
            run_shadow_r <= run_out;
        end else begin
            shadow_r     <= shadow_r;
            run_shadow_r <= run_shadow_r;
        end
    end

    // Status flags follow the shadow one edge later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            warn_r      <= 1'b0;
            bcd_error_r <= 1'b0;
        end else begin
            bcd_error_r <= bcd_word_invalid(shadow_r);
            warn_r      <= !run_shadow_r && !bcd_word_invalid(shadow_r) &&
                           (shadow_r != 16'h0000) && (shadow_r < WARN_THRESH);
        end
    end

    // Output registers; segments and anodes update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            seg_n_r <= SEG_BLANK;
            an_n_r  <= 4'hF;
        end else begin
            seg_n_r <= seg_next_s;
            an_n_r  <= an_next_s;
        end
    end

    assign seg_n     = seg_n_r;
    assign an_n      = an_n_r;
    assign warn      = warn_r;
    assign bcd_error = bcd_error_r;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios plus random
// time values, checked each cycle against a frame/time-based model.
module tb_bcd_scan_display;

    localparam int          SCAN_DIV     = 8;
    localparam int          GHOST_CYCLES = 2;
    localparam int          BLINK_DIV    = 64;
    localparam logic [15:0] WARN_THRESH  = 16'h0010;
    localparam int          FRAME        = 4 * SCAN_DIV;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] time_display = 16'h0000;
    logic        run_out = 1'b0;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        warn;
    logic        bcd_error;

    int checks = 0;
    int failures = 0;

    bcd_scan_display #(
        .SCAN_DIV     (SCAN_DIV),
        .GHOST_CYCLES (GHOST_CYCLES),
        .BLINK_DIV    (BLINK_DIV),
        .WARN_THRESH  (WARN_THRESH)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .time_display (time_display),
        .run_out      (run_out),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .warn         (warn),
        .bcd_error    (bcd_error)
    );

    always #5 Clk = ~Clk;

    // Reference glyphs for decimal digits.
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Model state: edges since reset, frame snapshot, flags, blinking age.
    bit          m_valid = 1'b0;
    int          m_n, m_slot, m_idx, m_age, m_dig;
    logic [15:0] m_shadow;
    logic        m_run, m_warn, m_err, m_blink, m_off;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_warn, exp_err, seg_care;

    // Reference model: what the outputs must be after each rising edge.
    always @(posedge Clk) begin
        if (Reset) begin
            m_valid = 1'b1; m_n = 0; m_age = 0;
            m_shadow = 16'h0000; m_run = 1'b0; m_warn = 1'b0; m_err = 1'b0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_warn = 1'b0; exp_err = 1'b0;
            seg_care = 1'b1;
        end else if (m_valid) begin
            m_slot  = m_n % SCAN_DIV;
            m_idx   = (m_n / SCAN_DIV) % 4;
            m_blink = m_run || m_warn;
            m_off   = m_blink && (((m_age / BLINK_DIV) % 2) == 1);
            exp_an  = (m_slot < GHOST_CYCLES || m_off) ? 4'hF : ~(4'b0001 << m_idx);
            seg_care = (exp_an != 4'hF);
            m_dig   = int'((m_shadow >> (4 * m_idx)) & 16'h000F);
            if (m_err) exp_seg = 7'b0111111;
            else if (m_idx > 0 && (m_shadow >> (4 * m_idx)) == 16'h0000) exp_seg = 7'h7F;
            else exp_seg = glyph(m_dig);
            exp_err = 1'b0;
            for (int k = 0; k < 4; k++)
                if (((m_shadow >> (4 * k)) & 16'h000F) > 16'd9) exp_err = 1'b1;
            exp_warn = !m_run && !exp_err && m_shadow != 16'h0000 && m_shadow < WARN_THRESH;
            m_age = m_blink ? m_age + 1 : 0;
            if (m_n % FRAME == FRAME - 1) begin
                m_shadow = time_display;
                m_run    = run_out;
            end
            m_warn = exp_warn;
            m_err  = exp_err;
            m_n++;
        end
    end

    // Per-cycle comparison of DUT outputs with the model, away from the edge.
    always @(negedge Clk) begin
        if (m_valid) begin
            checks++;
            if (an_n !== exp_an) begin
                failures++;
                $display("FAIL an_n t=%0t got=%h exp=%h", $time, an_n, exp_an);
            end
            checks++;
            if (warn !== exp_warn || bcd_error !== exp_err) begin
                failures++;
                $display("FAIL flags t=%0t got warn=%b err=%b exp warn=%b err=%b",
                         $time, warn, bcd_error, exp_warn, exp_err);
            end
            if (seg_care) begin
                checks++;
                if (seg_n !== exp_seg) begin
                    failures++;
                    $display("FAIL seg_n t=%0t got=%b exp=%b", $time, seg_n, exp_seg);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic lit(input string name, input logic [15:0] got, input logic [15:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end
    endtask

    // Bounded wait for a given anode pattern; a timeout counts as a failure.
    task automatic wait_an(input logic [3:0] pat, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge Clk);
            if (an_n === pat) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting an_n=%b", name, pat);
        end
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    logic [15:0] rv;
    int          kind;

    initial begin
        // 1: reset then a two-digit value
        step(3);
        lit("reset_an", {12'h0, an_n}, 16'h000F);
        lit("reset_seg", {9'h0, seg_n}, 16'h007F);
        Reset = 1'b0;
        time_display = 16'h0060;
        step(40);
        wait_an(4'b1101, "d1_wait");
        lit("d1_six", {9'h0, seg_n}, 16'h0002);
        wait_an(4'b1110, "d0_wait");
        lit("d0_zero", {9'h0, seg_n}, 16'h0040);
        lit("warn_0060", {15'h0, warn}, 16'h0000);

        // 2: mid-frame change
        step(5);
        time_display = 16'h0059;
        step(70);
        wait_an(4'b1101, "d1b_wait");
        lit("d1_five", {9'h0, seg_n}, 16'h0012);

        // 3: low-time warning and its threshold
        time_display = 16'h0009;
        step(80);
        lit("warn_0009", {15'h0, warn}, 16'h0001);
        step(300);
        time_display = 16'h0010;
        step(80);
        lit("warn_0010", {15'h0, warn}, 16'h0000);

        // 4: run-out on zero
        time_display = 16'h0000;
        run_out = 1'b1;
        step(300);

        // 5: invalid BCD then recovery
        run_out = 1'b0;
        time_display = 16'h00A5;
        step(80);
        lit("err_00A5", {15'h0, bcd_error}, 16'h0001);
        wait_an(4'b0111, "d3_wait");
        lit("d3_dash", {9'h0, seg_n}, 16'h003F);
        time_display = 16'h1234;
        step(80);
        lit("err_clear", {15'h0, bcd_error}, 16'h0000);

        // 6: reset in the middle of a blinking scan
        time_display = 16'h0000;
        run_out = 1'b1;
        step(150);
        Reset = 1'b1;
        step(1);
        lit("mid_rst_an", {12'h0, an_n}, 16'h000F);
        lit("mid_rst_seg", {9'h0, seg_n}, 16'h007F);
        lit("mid_rst_flags", {14'h0, warn, bcd_error}, 16'h0000);
        Reset = 1'b0;
        run_out = 1'b0;
        step(100);

        // Random time values, run-out and occasional resets
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1: rv = rand_bcd();
                2: begin
                    rv = 16'($urandom_range(0, 15));
                    if (rv > 16'd9) rv = 16'h0010 + (rv - 16'd10);
                end
                3: rv = 16'h0000;
                4: begin
                    rv = 16'($urandom());
                    rv[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
                end
                default: begin
                    rv = rand_bcd();
                    Reset = 1'b1;
                    step(int'($urandom_range(1, 2)));
                    Reset = 1'b0;
                end
            endcase
            time_display = rv;
            run_out = ($urandom_range(0, 3) == 0);
            step(int'($urandom_range(5, 250)));
        end

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
